// File: rtl/calc_op_sequencer.sv
// Calculator control sequencer: synchronises and edge-detects the operation
// buttons, freezes the operand digits, waits out the arithmetic latency and
// then holds the BCD result (or an error pattern) for the display path.
module calc_op_sequencer #(
    parameter int unsigned CALC_LAT   = 4,  // tick-cycles from operand latch to result capture (1..15)
    parameter int unsigned HOLD_TICKS = 0   // tick-cycles SHOW persists; 0 = hold forever
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick,
    input  logic        original,
    input  logic [3:0]  operations,
    input  logic [15:0] digits_in,
    input  logic [15:0] result_bcd,
    input  logic        result_neg,
    output logic [15:0] opnd_q,
    output logic [3:0]  op_sel,
    output logic [15:0] disp_bcd,
    output logic        show_result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_COMPUTE,
        S_SHOW,
        S_ERR
    } state_e;

    localparam logic [3:0]  CNT_INIT  = 4'(CALC_LAT - 1);
    localparam logic [15:0] HOLD_LAST = (HOLD_TICKS == 0) ? 16'd0 : 16'(HOLD_TICKS - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] hold_q;
    logic [3:0]  ops_s1_q, ops_s2_q, ops_prev_q;
    logic        orig_s1_q, orig_s2_q;
    logic [3:0]  op_edge;
    logic [3:0]  op_pick;

    // Two-flop synchronisers for the asynchronous button inputs, clocked every cycle.
    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the chain work.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ops_s1_q  <= 4'b0;
            ops_s2_q  <= 4'b0;
            orig_s1_q <= 1'b0;
            orig_s2_q <= 1'b0;
        end else begin
            ops_s1_q  <= operations;
            ops_s2_q  <= ops_s1_q;
            orig_s1_q <= original;
            orig_s2_q <= orig_s1_q;
        end
    end

    // Rising edges since the previous tick; keep only the lowest index (add > mul > div > sub).
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        op_edge = ops_s2_q & ~ops_prev_q;
        op_pick = op_edge & (~op_edge + 4'd1);
    end

    // Sequencer FSM with registered outputs; transitions only on tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= 16'd0;
            ops_prev_q  <= 4'b0;
            opnd_q      <= 16'h0;
            op_sel      <= 4'b0;
            disp_bcd    <= 16'h0;
            show_result <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Live operand digits while idle, refreshed every clock.
            if (state_q == S_IDLE) begin
                disp_bcd <= digits_in;
            end
            if (tick) begin
                ops_prev_q <= ops_s2_q;
                done       <= 1'b0;
                if (orig_s2_q) begin
                    // Return to operand display; aborts any in-flight compute.
                    state_q     <= S_IDLE;
                    op_sel      <= 4'b0;
                    busy        <= 1'b0;
                    show_result <= 1'b0;
                    err         <= 1'b0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (|op_edge) begin
                                opnd_q  <= digits_in;
                                op_sel  <= op_pick;
                                busy    <= 1'b1;
                                state_q <= S_LATCH;
                            end
                        end
                        S_LATCH: begin
                            // Divide with a zero divisor {d3,d2} never reaches the divider.
                            if (op_sel[2] && (opnd_q[15:8] == 8'h00)) begin
                                state_q     <= S_ERR;
                                busy        <= 1'b0;
                                err         <= 1'b1;
                                show_result <= 1'b1;
                                done        <= 1'b1;
                                disp_bcd    <= 16'hEEEE;
                            end else begin
                                state_q <= S_COMPUTE;
                                cnt_q   <= CNT_INIT;
                            end
                        end
                        S_COMPUTE: begin
                            if (cnt_q == 4'd0) begin
                                // Negative subtraction shows a minus glyph in the d0 field.
                                disp_bcd    <= (op_sel[3] && result_neg) ?
                                               {result_bcd[15:4], 4'hF} : result_bcd;
                                state_q     <= S_SHOW;
                                busy        <= 1'b0;
                                show_result <= 1'b1;
                                done        <= 1'b1;
                                hold_q      <= 16'd0;
                            end else begin
                                cnt_q <= cnt_q - 4'd1;
                            end
                        end
                        S_SHOW: begin
                            if (|op_edge) begin
                                // Chained operation: relatch the live digits.
                                opnd_q      <= digits_in;
                                op_sel      <= op_pick;
                                busy        <= 1'b1;
                                show_result <= 1'b0;
                                state_q     <= S_LATCH;
                            end else if ((HOLD_TICKS != 0) && (hold_q == HOLD_LAST)) begin
                                state_q     <= S_IDLE;
                                op_sel      <= 4'b0;
                                show_result <= 1'b0;
                            end else if (HOLD_TICKS != 0) begin
                                hold_q <= hold_q + 16'd1;
                            end
                        end
                        S_ERR: begin
                            // The edge only clears the error; it is not relatched.
                            if (|op_edge) begin
                                state_q     <= S_IDLE;
                                op_sel      <= 4'b0;
                                err         <= 1'b0;
                                show_result <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed testbench for calc_op_sequencer: one task per scenario, inline checks.
// A second instance with HOLD_TICKS=3 shares all inputs to exercise auto-return.
`timescale 1ns/1ps
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tick;
    logic        original;
    logic [3:0]  operations;
    logic [15:0] digits_in;
    logic [15:0] result_bcd;
    logic        result_neg;

    logic [15:0] opnd_q, disp_bcd;
    logic [3:0]  op_sel;
    logic        show_result, busy, done, err;

    logic [15:0] h_opnd_q, h_disp_bcd;
    logic [3:0]  h_op_sel;
    logic        h_show_result, h_busy, h_done, h_err;

    logic [7:0]  flags, h_flags;
    assign flags   = {busy, done, err, show_result, op_sel};
    assign h_flags = {h_busy, h_done, h_err, h_show_result, h_op_sel};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    calc_op_sequencer #(.CALC_LAT(4), .HOLD_TICKS(0)) u_dut (
        .clk(clk), .rstn(rstn), .tick(tick), .original(original),
        .operations(operations), .digits_in(digits_in),
        .result_bcd(result_bcd), .result_neg(result_neg),
        .opnd_q(opnd_q), .op_sel(op_sel), .disp_bcd(disp_bcd),
        .show_result(show_result), .busy(busy), .done(done), .err(err)
    );

    calc_op_sequencer #(.CALC_LAT(4), .HOLD_TICKS(3)) u_hold (
        .clk(clk), .rstn(rstn), .tick(tick), .original(original),
        .operations(operations), .digits_in(digits_in),
        .result_bcd(result_bcd), .result_neg(result_neg),
        .opnd_q(h_opnd_q), .op_sel(h_op_sel), .disp_bcd(h_disp_bcd),
        .show_result(h_show_result), .busy(h_busy), .done(h_done), .err(h_err)
    );

    // One tick-cycle: two clocks for the synchronisers, then a single-clock tick.
    // Ends on the falling edge after the tick edge, where outputs are sampled.
    task automatic step();
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] op);
        operations = op;
        step();
        operations = 4'b0;
    endtask

    task automatic go_idle();
        original = 1'b1;
        step();
        original = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        if (flags !== 8'h00) begin $display("FAIL reset_flags got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'h0) begin $display("FAIL reset_disp got %h exp %h", disp_bcd, 16'h0); miscompares++; end
        vectors++;
        if (opnd_q !== 16'h0) begin $display("FAIL reset_opnd got %h exp %h", opnd_q, 16'h0); miscompares++; end
        vectors++;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_add();
        int busy_cnt;
        int done_cnt;
        digits_in  = 16'h1234;
        result_bcd = 16'h2468;
        result_neg = 1'b0;
        go_idle();
        press(4'b0001);
        if (flags !== 8'b1000_0001) begin $display("FAIL add_latch got %b exp %b", flags, 8'b1000_0001); miscompares++; end
        vectors++;
        busy_cnt = int'(busy);
        done_cnt = int'(done);
        for (int i = 0; i < 4; i++) begin
            step();
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        if (busy_cnt !== 5) begin $display("FAIL add_busy_ticks got %0d exp %0d", busy_cnt, 5); miscompares++; end
        vectors++;
        if (done_cnt !== 0) begin $display("FAIL add_early_done got %0d exp %0d", done_cnt, 0); miscompares++; end
        vectors++;
        step();
        if (flags !== 8'b0101_0001) begin $display("FAIL add_show got %b exp %b", flags, 8'b0101_0001); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'h2468) begin $display("FAIL add_disp got %h exp %h", disp_bcd, 16'h2468); miscompares++; end
        vectors++;
        step();
        if (flags !== 8'b0001_0001) begin $display("FAIL add_done_pulse got %b exp %b", flags, 8'b0001_0001); miscompares++; end
        vectors++;
    endtask

    task automatic test_priority();
        int  latches;
        logic prev_busy;
        digits_in = 16'h1234;
        go_idle();
        operations = 4'b0110;
        step();
        if (flags !== 8'b1000_0010) begin $display("FAIL prio_latch got %b exp %b", flags, 8'b1000_0010); miscompares++; end
        vectors++;
        latches   = 1;
        prev_busy = busy;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy && !prev_busy) latches++;
            prev_busy = busy;
        end
        operations = 4'b0;
        if (latches !== 1) begin $display("FAIL prio_held_latches got %0d exp %0d", latches, 1); miscompares++; end
        vectors++;
        if (flags !== 8'b0001_0010) begin $display("FAIL prio_show got %b exp %b", flags, 8'b0001_0010); miscompares++; end
        vectors++;
    endtask

    task automatic test_div_err();
        digits_in = 16'h0057;
        go_idle();
        press(4'b0100);
        if (flags !== 8'b1000_0100) begin $display("FAIL div_latch got %b exp %b", flags, 8'b1000_0100); miscompares++; end
        vectors++;
        step();
        if (flags !== 8'b0111_0100) begin $display("FAIL div_err_flags got %b exp %b", flags, 8'b0111_0100); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'hEEEE) begin $display("FAIL div_err_disp got %h exp %h", disp_bcd, 16'hEEEE); miscompares++; end
        vectors++;
        step();
        if (flags !== 8'b0011_0100) begin $display("FAIL div_err_hold got %b exp %b", flags, 8'b0011_0100); miscompares++; end
        vectors++;
        press(4'b0001);
        if (flags !== 8'h00) begin $display("FAIL div_clear got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        step();
        if (flags !== 8'h00) begin $display("FAIL div_no_relatch got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'h0057) begin $display("FAIL div_idle_disp got %h exp %h", disp_bcd, 16'h0057); miscompares++; end
        vectors++;
    endtask

    task automatic test_sub();
        digits_in  = 16'h4321;
        result_bcd = 16'h0003;
        result_neg = 1'b1;
        go_idle();
        press(4'b1000);
        if (flags !== 8'b1000_1000) begin $display("FAIL sub_latch got %b exp %b", flags, 8'b1000_1000); miscompares++; end
        vectors++;
        digits_in = 16'h9999;
        step();
        if (opnd_q !== 16'h4321) begin $display("FAIL sub_opnd_frozen got %h exp %h", opnd_q, 16'h4321); miscompares++; end
        vectors++;
        repeat (4) step();
        if (flags !== 8'b0101_1000) begin $display("FAIL sub_show got %b exp %b", flags, 8'b0101_1000); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'h000F) begin $display("FAIL sub_minus got %h exp %h", disp_bcd, 16'h000F); miscompares++; end
        vectors++;
        if (opnd_q !== 16'h4321) begin $display("FAIL sub_opnd_end got %h exp %h", opnd_q, 16'h4321); miscompares++; end
        vectors++;
    endtask

    task automatic test_back_to_back();
        // Starts in SHOW from the subtraction; a new press relatches the live digits.
        result_neg = 1'b0;
        result_bcd = 16'h1111;
        press(4'b0001);
        if (flags !== 8'b1000_0001) begin $display("FAIL b2b_latch got %b exp %b", flags, 8'b1000_0001); miscompares++; end
        vectors++;
        if (opnd_q !== 16'h9999) begin $display("FAIL b2b_opnd got %h exp %h", opnd_q, 16'h9999); miscompares++; end
        vectors++;
        repeat (5) step();
        if (disp_bcd !== 16'h1111) begin $display("FAIL b2b_disp got %h exp %h", disp_bcd, 16'h1111); miscompares++; end
        vectors++;
    endtask

    task automatic test_original();
        int done_seen;
        digits_in = 16'h1234;
        go_idle();
        press(4'b0001);
        step();
        original = 1'b1;
        step();
        original = 1'b0;
        if (flags !== 8'h00) begin $display("FAIL orig_abort got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            done_seen += int'(done);
        end
        if (done_seen !== 0) begin $display("FAIL orig_no_done got %0d exp %0d", done_seen, 0); miscompares++; end
        vectors++;
    endtask

    task automatic test_mid_reset();
        digits_in = 16'h1234;
        go_idle();
        press(4'b0001);
        step();
        #2;
        rstn = 1'b0;
        #1;
        if (flags !== 8'h00) begin $display("FAIL rst_async_flags got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        if (opnd_q !== 16'h0) begin $display("FAIL rst_async_opnd got %h exp %h", opnd_q, 16'h0); miscompares++; end
        vectors++;
        if (disp_bcd !== 16'h0) begin $display("FAIL rst_async_disp got %h exp %h", disp_bcd, 16'h0); miscompares++; end
        vectors++;
        @(negedge clk);
        rstn = 1'b1;
        step();
        if (flags !== 8'h00) begin $display("FAIL rst_idle got %b exp %b", flags, 8'h00); miscompares++; end
        vectors++;
        press(4'b0010);
        if (flags !== 8'b1000_0010) begin $display("FAIL rst_relatch got %b exp %b", flags, 8'b1000_0010); miscompares++; end
        vectors++;
    endtask

    task automatic test_hold();
        digits_in  = 16'h0042;
        result_bcd = 16'h0084;
        result_neg = 1'b0;
        go_idle();
        press(4'b0001);
        repeat (5) step();
        if (h_flags !== 8'b0101_0001) begin $display("FAIL hold_enter got %b exp %b", h_flags, 8'b0101_0001); miscompares++; end
        vectors++;
        repeat (2) step();
        if (h_show_result !== 1'b1) begin $display("FAIL hold_persist got %b exp %b", h_show_result, 1'b1); miscompares++; end
        vectors++;
        step();
        if (h_flags !== 8'h00) begin $display("FAIL hold_exit got %b exp %b", h_flags, 8'h00); miscompares++; end
        vectors++;
        if (flags !== 8'b0001_0001) begin $display("FAIL hold_forever got %b exp %b", flags, 8'b0001_0001); miscompares++; end
        vectors++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tick       = 1'b0;
        original   = 1'b0;
        operations = 4'b0;
        digits_in  = 16'h0;
        result_bcd = 16'h0;
        result_neg = 1'b0;
        test_reset();
        test_add();
        test_priority();
        test_div_err();
        test_sub();
        test_back_to_back();
        test_original();
        test_mid_reset();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
